// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - pipelined sign/zero/upper immediate extender with stall/flush slots
// Define IMM_EXT_LOAD_EN to turn modes 1xx into LB/LBU/LH/LHU extension of ld_word.
module imm_extend_pipe #(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 32,
  parameter int STAGES    = 1,
  parameter int LUI_SHIFT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [2:0]       mode,
  input  logic [IN_W-1:0]  data_in,
  input  logic [OUT_W-1:0] ld_word,
  input  logic [1:0]       byte_off,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data
);

  logic [OUT_W-1:0] sign_ext;
  logic [OUT_W-1:0] zero_ext;
  logic [OUT_W-1:0] upper_ext;
  logic [OUT_W-1:0] result;

  assign sign_ext  = OUT_W'($signed(data_in));
  assign zero_ext  = OUT_W'(data_in);
  assign upper_ext = OUT_W'(data_in) << LUI_SHIFT;

`ifdef IMM_EXT_LOAD_EN
  logic [31:0] lw32;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign lw32    = ld_word[31:0];
  assign ld_half = byte_off[1] ? lw32[31:16] : lw32[15:0];

  always_comb begin
    ld_byte = lw32[7:0];
    case (byte_off)
      2'd1:    ld_byte = lw32[15:8];
      2'd2:    ld_byte = lw32[23:16];
      2'd3:    ld_byte = lw32[31:24];
      default: ld_byte = lw32[7:0];
    endcase
  end
`else
  // Load lanes are only wired up in the load-extension build.
  logic unused_load;
  assign unused_load = ^{ld_word, byte_off};
`endif

  always_comb begin
    result = sign_ext;
    case (mode)
      3'b000:  result = sign_ext;
      3'b001:  result = zero_ext;
      3'b010:  result = upper_ext;
      3'b011:  result = '0;
`ifdef IMM_EXT_LOAD_EN
      3'b100:  result = OUT_W'($signed(ld_byte));
      3'b101:  result = OUT_W'(ld_byte);
      3'b110:  result = OUT_W'($signed(ld_half));
      3'b111:  result = OUT_W'(ld_half);
`endif
      default: result = sign_ext;
    endcase
  end

  logic [STAGES-1:0] slot_valid;
  logic [OUT_W-1:0]  slot_data [STAGES];

  // Flush clears only the valids; data registers keep their contents.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_valid <= '0;
      for (int k = 0; k < STAGES; k++) slot_data[k] <= '0;
    end else if (flush) begin
      slot_valid <= '0;
    end else if (!stall) begin
      slot_valid[0] <= in_valid;
      slot_data[0]  <= result;
      for (int k = 1; k < STAGES; k++) begin
        slot_valid[k] <= slot_valid[k-1];
        slot_data[k]  <= slot_data[k-1];
      end
    end
  end

  assign out_valid = slot_valid[STAGES-1];
  assign out_data  = slot_data[STAGES-1];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - directed-vector bench for imm_extend_pipe (IN_W=16, OUT_W=32, STAGES=2)
module tb_imm_extend_pipe;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [2:0]  mode = 3'b000;
  logic [15:0] data_in = 16'h0;
  logic [31:0] ld_word = 32'h0;
  logic [1:0]  byte_off = 2'd0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;

  int n_applied = 0;
  int n_miss    = 0;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .STAGES(2), .LUI_SHIFT(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .mode(mode),
    .data_in(data_in), .ld_word(ld_word), .byte_off(byte_off),
    .stall(stall), .flush(flush), .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clock = ~clock;

  logic [2:0]  v_mode [8];
  logic [15:0] v_data [8];
  logic [1:0]  v_off  [8];
  logic [31:0] v_exp  [8];
  int          n_vec;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_applied++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] m, input logic [15:0] d);
    in_valid = v;
    mode     = m;
    data_in  = d;
  endtask

  task automatic add_vec(input logic [2:0] m, input logic [15:0] d, input logic [1:0] off,
                         input logic [31:0] exp);
    v_mode[n_vec] = m;
    v_data[n_vec] = d;
    v_off[n_vec]  = off;
    v_exp[n_vec]  = exp;
    n_vec++;
  endtask

  initial begin
    #2;
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_data", out_data, 32'h0);
    tick();
    reset = 1'b0;

    // two-cycle latency on a single SIGN item
    drive(1'b1, 3'b000, 16'h8001);
    tick();
    chk("lat_early", {31'b0, out_valid}, 32'h0);
    drive(1'b0, 3'b000, 16'h0);
    tick();
    chk("lat_valid", {31'b0, out_valid}, 32'h1);
    chk("lat_data", out_data, 32'hFFFF8001);
    tick();
    chk("lat_drain", {31'b0, out_valid}, 32'h0);

    // back-to-back stream, one result per cycle
    n_vec = 0;
    add_vec(3'b001, 16'h8001, 2'd0, 32'h00008001);
    add_vec(3'b010, 16'h1234, 2'd0, 32'h12340000);
    add_vec(3'b011, 16'hBEEF, 2'd0, 32'h00000000);
    add_vec(3'b000, 16'h7FFF, 2'd0, 32'h00007FFF);
`ifdef IMM_EXT_LOAD_EN
    ld_word = 32'h80FF7F01;
    add_vec(3'b100, 16'h0000, 2'd2, 32'hFFFFFFFF);
    add_vec(3'b101, 16'h0000, 2'd3, 32'h00000080);
    add_vec(3'b110, 16'h0000, 2'd0, 32'h00007F01);
    add_vec(3'b111, 16'h0000, 2'd2, 32'h000080FF);
    add_vec(3'b110, 16'h0000, 2'd2, 32'hFFFF80FF);
`else
    ld_word = 32'h80FF7F01;
    add_vec(3'b100, 16'h8001, 2'd2, 32'hFFFF8001);
    add_vec(3'b111, 16'h00FF, 2'd3, 32'h000000FF);
    add_vec(3'b110, 16'hC000, 2'd0, 32'hFFFFC000);
`endif
    for (int i = 0; i <= n_vec; i++) begin
      if (i < n_vec) begin
        drive(1'b1, v_mode[i], v_data[i]);
        byte_off = v_off[i];
      end else begin
        drive(1'b0, 3'b000, 16'h0);
      end
      tick();
      if (i >= 1) begin
        chk("strm_valid", {31'b0, out_valid}, 32'h1);
        chk("strm_data", out_data, v_exp[i-1]);
      end
    end
    tick();
    chk("strm_drain", {31'b0, out_valid}, 32'h0);

    // stall with two items in flight
    drive(1'b1, 3'b000, 16'h0001);
    tick();
    drive(1'b1, 3'b001, 16'hFFFF);
    tick();
    chk("stl_pre", out_data, 32'h00000001);
    stall = 1'b1;
    drive(1'b1, 3'b010, 16'hAAAA);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stl_valid", {31'b0, out_valid}, 32'h1);
      chk("stl_data", out_data, 32'h00000001);
    end
    stall = 1'b0;
    drive(1'b0, 3'b000, 16'h0);
    tick();
    chk("stl_rel_valid", {31'b0, out_valid}, 32'h1);
    chk("stl_rel_data", out_data, 32'h0000FFFF);
    tick();
    chk("stl_drain", {31'b0, out_valid}, 32'h0);

    // flush wins over stall; next accepted input still takes two cycles
    drive(1'b1, 3'b000, 16'h1111);
    tick();
    drive(1'b1, 3'b000, 16'h2222);
    stall = 1'b1;
    flush = 1'b1;
    tick();
    chk("fl_valid", {31'b0, out_valid}, 32'h0);
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b1, 3'b000, 16'hFFFF);
    tick();
    chk("fl_gap", {31'b0, out_valid}, 32'h0);
    drive(1'b0, 3'b000, 16'h0);
    tick();
    chk("fl_new_valid", {31'b0, out_valid}, 32'h1);
    chk("fl_new_data", out_data, 32'hFFFFFFFF);

    // asynchronous reset between edges, mid-stream and mid-stall
    drive(1'b1, 3'b001, 16'h4321);
    tick();
    drive(1'b1, 3'b001, 16'h5678);
    tick();
    stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'h0);
    chk("arst_data", out_data, 32'h0);
    tick();
    reset = 1'b0;
    stall = 1'b0;
    drive(1'b1, 3'b010, 16'h00AB);
    tick();
    chk("rec_gap", {31'b0, out_valid}, 32'h0);
    drive(1'b0, 3'b000, 16'h0);
    tick();
    chk("rec_valid", {31'b0, out_valid}, 32'h1);
    chk("rec_data", out_data, 32'h00AB0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule
